// File: rtl/memory_port_arbiter_pkg.sv
// Shared arbiter state encodings and memory length constants.
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_F = 2'd1,
        ARB_WAIT_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] MEM_LEN_WORD = 2'd3;

endpackage

// File: rtl/memory_port_arbiter_timeout.sv
// Loadable countdown used to bound how long a memory access may stay outstanding.
module arb_timeout_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and data access using a
// req/done handshake, data priority with a fetch starvation guard, and a timeout.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_length,
    input  logic                  d_unsigned,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_length,
    output logic                  mem_load,
    output logic                  mem_store,
    output logic                  mem_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  owner_data,
    output logic                  bus_error,
    output logic [1:0]            dbgState
);

    // Handshake: a requester holds req until its done pulse; req is only
    // sampled in IDLE, so a request raised while busy waits for the next IDLE.

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_t          state, nextState;
    logic [STREAK_W-1:0] streak;
    logic                isWrite;
    logic                ownerIsData;
    logic                grantData, grantFetch, finish, timedOut;
    logic                waiting, tmoExpired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        finish     = 1'b0;
        timedOut   = 1'b0;
        case (state)
            ARB_IDLE: begin
                // Data wins unless fetch has waited through a full data streak.
                if (d_req && (!if_req || (streak != STREAK_W'(MAX_DATA_STREAK)))) begin
                    grantData = 1'b1;
                    nextState = ARB_WAIT_D;
                end else if (if_req) begin
                    grantFetch = 1'b1;
                    nextState  = ARB_WAIT_F;
                end
            end
            ARB_WAIT_F, ARB_WAIT_D: begin
                if (mem_ready) begin
                    finish    = 1'b1;
                    nextState = ARB_RESP;
                end else if (tmoExpired) begin
                    timedOut  = 1'b1;
                    nextState = ARB_RESP;
                end
            end
            default: nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_length   <= '0;
            mem_unsigned <= 1'b0;
            isWrite      <= 1'b0;
            ownerIsData  <= 1'b0;
            streak       <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            bus_error    <= 1'b0;
        end else begin
            if (grantData) begin
                mem_addr     <= d_addr;
                mem_wdata    <= d_wdata;
                mem_length   <= d_length;
                mem_unsigned <= d_unsigned;
                isWrite      <= d_write;
                ownerIsData  <= 1'b1;
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != STREAK_W'(MAX_DATA_STREAK)) begin
                    streak <= streak + 1'b1;
                end
            end
            if (grantFetch) begin
                mem_addr     <= if_addr;
                mem_wdata    <= '0;
                mem_length   <= MEM_LEN_WORD;
                mem_unsigned <= 1'b0;
                isWrite      <= 1'b0;
                ownerIsData  <= 1'b0;
                streak       <= '0;
            end
            if (finish) begin
                if (!ownerIsData) begin
                    if_rdata <= mem_rdata;
                end else if (!isWrite) begin
                    d_rdata <= mem_rdata;
                end
            end
            if (timedOut) begin
                bus_error <= 1'b1;
                if (ownerIsData) begin
                    d_rdata <= '0;
                end else begin
                    if_rdata <= '0;
                end
            end
        end
    end

    assign waiting = (state == ARB_WAIT_F) || (state == ARB_WAIT_D);

    arb_timeout_counter #(
        .WIDTH(TMO_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ARB_RESP),
        .load     (grantData || grantFetch),
        .loadValue(TMO_W'(TIMEOUT_CYCLES - 1)),
        .enable   (waiting && !mem_ready),
        .expired  (tmoExpired)
    );

    assign mem_load   = (state == ARB_WAIT_F) || ((state == ARB_WAIT_D) && !isWrite);
    assign mem_store  = (state == ARB_WAIT_D) && isWrite;
    assign owner_data = (state == ARB_WAIT_D) || ((state == ARB_RESP) && ownerIsData);
    assign if_done    = (state == ARB_RESP) && !ownerIsData;
    assign d_done     = (state == ARB_RESP) && ownerIsData;
    assign dbgState   = state;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized and directed transaction-level check of memory_port_arbiter against
// a requester/memory model derived from the arbitration and latency rules.
module tb_memory_port_arbiter;

    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_write, d_unsigned, mem_ready;
    logic [DW-1:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]    d_length;
    logic [DW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic          if_done, d_done, mem_load, mem_store, mem_unsigned, owner_data, bus_error;
    logic [1:0]    mem_length, dbgState;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_length(d_length), .d_unsigned(d_unsigned), .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_length(mem_length),
        .mem_load(mem_load), .mem_store(mem_store), .mem_unsigned(mem_unsigned),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner_data(owner_data), .bus_error(bus_error), .dbgState(dbgState)
    );

    int errors = 0;
    int checks = 0;

    // Model state: pending requests, data streak seen by a waiting fetch, sticky error, read data.
    bit            fPend, dPend;
    int            streakM;
    bit            busErrM;
    logic [DW-1:0] ifRdM, dRdM;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setFetch(input logic [DW-1:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
        fPend   = 1'b1;
    endtask

    task automatic setData(input bit wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [1:0] len, input bit uns);
        d_req      = 1'b1;
        d_write    = wr;
        d_addr     = addr;
        d_wdata    = wdata;
        d_length   = len;
        d_unsigned = uns;
        dPend      = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_strobes"}, {30'd0, mem_load, mem_store}, '0);
        check({tag, "_done"}, {30'd0, if_done, d_done}, '0);
        check({tag, "_owner"}, owner_data, '0);
    endtask

    // Called at a falling edge in IDLE with at least one request pending.
    // lat = wait cycles before mem_ready; lat >= TMO means memory never answers.
    task automatic serve(input int lat, input logic [DW-1:0] rdata, input bit holdD);
        bit winD, tmo, done;
        winD = dPend && (!fPend || streakM != MAXS);
        if (winD) streakM = fPend ? ((streakM < MAXS) ? streakM + 1 : MAXS) : 0;
        else      streakM = 0;
        tmo  = (lat >= TMO);
        done = 1'b0;
        exp_q.push_back(winD ? d_addr : if_addr);
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < TMO && !done; c++) begin
            check("wait_load", mem_load, winD ? !d_write : 1'b1);
            check("wait_store", mem_store, winD ? d_write : 1'b0);
            check("wait_addr", mem_addr, exp_q[0]);
            check("wait_owner", owner_data, winD);
            check("wait_done", {30'd0, if_done, d_done}, '0);
            if (c == 0) begin
                check("wait_len", mem_length, winD ? d_length : 2'd3);
                check("wait_wdata", mem_wdata, winD ? d_wdata : '0);
                check("wait_uns", mem_unsigned, winD ? d_unsigned : 1'b0);
            end
            if (!tmo && c == lat) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            @(posedge clk); @(negedge clk);
            done = (!tmo && c == lat) || (tmo && c == TMO - 1);
        end
        void'(exp_q.pop_front());
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (tmo) begin
            busErrM = 1'b1;
            if (winD) dRdM = '0; else ifRdM = '0;
        end else if (!winD) begin
            ifRdM = rdata;
        end else if (!d_write) begin
            dRdM = rdata;
        end
        check("resp_if_done", if_done, !winD);
        check("resp_d_done", d_done, winD);
        check("resp_strobes", {30'd0, mem_load, mem_store}, '0);
        check("resp_owner", owner_data, winD);
        check("resp_if_rdata", if_rdata, ifRdM);
        check("resp_d_rdata", d_rdata, dRdM);
        check("resp_bus_error", bus_error, busErrM);
        if (winD && !holdD) begin
            d_req = 1'b0;
            dPend = 1'b0;
        end else if (!winD) begin
            if_req = 1'b0;
            fPend  = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        checkIdle("idle");
    endtask

    task automatic modelReset();
        fPend = 0; dPend = 0; streakM = 0; busErrM = 0; ifRdM = '0; dRdM = '0;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; d_req = 0; d_write = 0; d_unsigned = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_length = '0; mem_rdata = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("rst");
        check("rst_outputs", mem_addr | mem_wdata | if_rdata | d_rdata, '0);
        check("rst_flags", {28'd0, mem_length, mem_unsigned, bus_error}, '0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        checkIdle("post_rst");

        // Fetch only, two wait cycles.
        setFetch(32'h100);
        serve(2, 32'h0050_0093, 0);
        // Load to give d_rdata a value, then a store that must leave it alone.
        setData(0, 32'h3000, 32'h0, 2'd2, 0);
        serve(1, 32'h1234_5678, 0);
        setData(1, 32'h2000, 32'hDEAD_BEEF, 2'd2, 0);
        serve(0, 32'hFFFF_FFFF, 0);

        // Both pending, data held: expect D,D,D,D,F then data wins again from streak 0.
        setFetch(32'h200);
        setData(0, 32'h4000, 32'h0, 2'd3, 1);
        for (int i = 0; i < 5; i++) begin
            check("streak_owner_pred", {31'd0, dPend && (!fPend || streakM != MAXS)}, (i < 4) ? 1 : 0);
            serve($urandom_range(0, 3), $urandom, 1);
        end
        setFetch(32'h204);
        serve(0, $urandom, 1);
        check("streak_after_f", fPend, 1'b1);
        serve(0, $urandom, 0);
        serve(1, $urandom, 0);

        // Load that never completes, then a good fetch keeps bus_error high.
        setData(0, 32'h5000, 32'h0, 2'd2, 0);
        serve(TMO + 10, '0, 0);
        setFetch(32'h300);
        serve(1, 32'hCAFE_F00D, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if (!fPend && ($urandom_range(0, 1) == 1)) setFetch($urandom & 32'hFFFF_FFFC);
            if (!dPend && ($urandom_range(0, 1) == 1))
                setData($urandom_range(0, 1), $urandom, $urandom, 2'($urandom_range(0, 3)),
                        $urandom_range(0, 1));
            if (!fPend && !dPend) begin
                @(posedge clk); @(negedge clk);
                checkIdle("rand_idle");
            end else begin
                serve(($urandom_range(0, 19) == 0) ? TMO + 5 : $urandom_range(0, 5), $urandom, 0);
            end
        end

        // Async reset in the middle of a data wait.
        if (fPend || dPend) serve(0, $urandom, 0);
        if (fPend || dPend) serve(0, $urandom, 0);
        setData(0, 32'h6000, 32'h0, 2'd2, 0);
        @(posedge clk); @(negedge clk);
        check("pre_rst_load", mem_load, 1'b1);
        setFetch(32'h400);
        #2 reset = 1'b1;
        #1;
        check("async_strobes", {30'd0, mem_load, mem_store}, '0);
        check("async_done", {30'd0, if_done, d_done}, '0);
        check("async_bus_error", bus_error, 1'b0);
        @(posedge clk); @(negedge clk);
        d_req = 1'b0;
        modelReset();
        fPend = 1'b1;
        reset = 1'b0;
        checkIdle("rst_release");
        serve(1, 32'h0000_0013, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
